// File: rtl/avalon_pio_bidir_irq.sv
// ============================================================================
// Module  : avalon_pio_bidir_irq
// Brief   : Avalon-MM bidirectional PIO with set/clear, edge capture and IRQ.
// Revision: 1.0
// ============================================================================
`default_nettype none

module avalon_pio_bidir_irq #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] DATA_RESET  = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
    localparam logic [2:0] ARM_MAX      = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [2:0]       arm_q, arm_d;
    logic             irq_q, irq_d;

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] rise, fall, det;
    logic [WIDTH-1:0] rd_val;

    assign wr_en   = chipselect & ~write_n;
    assign wd      = writedata[WIDTH-1:0];
    assign in_sync = sync_q[SYNC_STAGES-1];
    assign rise    = in_sync & ~prev_q;
    assign fall    = ~in_sync & prev_q;

    // Detection stays off until the synchroniser and prev register have
    // filled with real pin values, so reset release never fakes an edge.
    always_comb begin
        det = '0;
        if (arm_q == ARM_MAX) begin
            if (EDGE_TYPE == 0)      det = rise;
            else if (EDGE_TYPE == 1) det = fall;
            else                     det = rise | fall;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irqmask_d  = irqmask_q;
        edgecap_d  = edgecap_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d     = in_sync;
        arm_d      = (arm_q == ARM_MAX) ? arm_q : arm_q + 3'd1;
        irq_d      = |(edgecap_q & irqmask_q);
        if (wr_en) begin
            case (address)
                ADDR_DATA:    data_out_d = wd;
                ADDR_DIR:     dir_d      = wd;
                ADDR_IRQMASK: irqmask_d  = wd;
                ADDR_EDGECAP: edgecap_d  = edgecap_q & ~wd;
                ADDR_OUTSET:  data_out_d = data_out_q | wd;
                ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
                default:      ;
            endcase
        end
        // A fresh edge overrides a simultaneous write-1-to-clear.
        edgecap_d = edgecap_d | det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= DATA_RESET;
            dir_q      <= DIR_RESET;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            arm_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            arm_q      <= arm_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:    rd_val = (dir_q & data_out_q) | (~dir_q & in_sync);
            ADDR_DIR:     rd_val = dir_q;
            ADDR_IRQMASK: rd_val = irqmask_q;
            ADDR_EDGECAP: rd_val = edgecap_q;
            default:      rd_val = '0;
        endcase
        readdata               = '0;
        readdata[WIDTH-1:0]    = rd_val;
    end

    assign out_port = data_out_q;
    assign oe_port  = dir_q;
    assign irq      = irq_q;

endmodule

`default_nettype wire
